// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus settle-counter FSM for the four slide switches; emits a stable word and a commit strobe.
// Optional change counter output chg_cnt is enabled by defining SWITCH_DEBOUNCER_CHG_CNT_EN.

module switch_debouncer_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_a,
  input  logic       sw_b,
  input  logic       sw_c,
  input  logic       sw_d,
  output logic [3:0] sw_db,
  output logic       changed
`ifdef SWITCH_DEBOUNCER_CHG_CNT_EN
  ,
  output logic [7:0] chg_cnt
`endif
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic {STABLE, SETTLING} state_t;

  logic [3:0]       raw;
  logic [3:0]       sync2;
  logic [3:0]       candidate;
  logic [CNT_W-1:0] cnt;
  state_t           state;

  assign raw = {sw_a, sw_b, sw_c, sw_d};

  for (genvar i = 0; i < 4; i++) begin : g_sync
    switch_debouncer_sync u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (raw[i]),
      .q    (sync2[i])
    );
  end

  // Any new word seen while settling restarts the count, so a commit always carries the final word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= STABLE;
      candidate <= 4'b0000;
      cnt       <= '0;
      sw_db     <= 4'b0000;
      changed   <= 1'b0;
`ifdef SWITCH_DEBOUNCER_CHG_CNT_EN
      chg_cnt   <= 8'd0;
`endif
    end else begin
      changed <= 1'b0;
      case (state)
        STABLE: begin
          if (sync2 != sw_db) begin
            state     <= SETTLING;
            candidate <= sync2;
            cnt       <= ONE;
          end else begin
            cnt <= '0;
          end
        end
        SETTLING: begin
          if (sync2 == sw_db) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (sync2 != candidate) begin
            candidate <= sync2;
            cnt       <= ONE;
          end else if (cnt == LAST) begin
            sw_db   <= candidate;
            changed <= 1'b1;
            state   <= STABLE;
            cnt     <= '0;
`ifdef SWITCH_DEBOUNCER_CHG_CNT_EN
            chg_cnt <= chg_cnt + 8'd1;
`endif
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus random switch activity against a run-length model.
module tb_switch_debouncer;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pins = 4'b0000;
  logic [3:0] sw_db;
  logic       changed;
`ifdef SWITCH_DEBOUNCER_CHG_CNT_EN
  logic [7:0] chg_cnt;
`endif

  int checks = 0;
  int passes = 0;

  // Model: the word the FSM sees is the pin value two edges old; commit when it has
  // been the same for D consecutive samples and differs from the committed word.
  logic [3:0] m_d1 = '0, m_d2 = '0, m_db = '0, m_prev = '0;
  logic       m_chg = 1'b0;
  int         m_rl = 0;
  logic [7:0] m_cnt = '0;
  int         commits = 0;

  switch_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_a   (pins[3]),
    .sw_b   (pins[2]),
    .sw_c   (pins[1]),
    .sw_d   (pins[0]),
    .sw_db  (sw_db),
    .changed(changed)
`ifdef SWITCH_DEBOUNCER_CHG_CNT_EN
    ,
    .chg_cnt(chg_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    logic [3:0] s;
    @(posedge clk);
    if (!rst_n) begin
      m_d1 = '0; m_d2 = '0; m_db = '0; m_prev = '0;
      m_chg = 1'b0; m_rl = 0; m_cnt = '0;
    end else begin
      s = m_d2;
      m_rl = (s == m_prev) ? m_rl + 1 : 1;
      m_prev = s;
      m_chg = (s != m_db) && (m_rl == D);
      if (m_chg) begin
        m_db = s;
        m_cnt = m_cnt + 8'd1;
        commits++;
      end
      m_d2 = m_d1;
      m_d1 = pins;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] exp_db;
    logic       exp_chg;
    pins = 4'b1010;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (sw_db !== 4'b0000 || changed !== 1'b0)
      $display("FAIL reset_hold: sw_db=%b changed=%b want 0000 0", sw_db, changed);
    else passes++;
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_db  = (e >= 6) ? 4'b1010 : 4'b0000;
      exp_chg = (e == 6);
      checks++;
      if (sw_db !== exp_db || changed !== exp_chg)
        $display("FAIL reset_release e%0d: sw_db=%b changed=%b want %b %b", e, sw_db, changed, exp_db, exp_chg);
      else passes++;
    end
  endtask

  task automatic test_clean_change();
    logic [3:0] exp_db;
    logic       exp_chg;
    pins = 4'b0011;
    repeat (8) tick();
    checks++;
    if (sw_db !== 4'b0011)
      $display("FAIL clean_setup: sw_db=%b want 0011", sw_db);
    else passes++;
    pins = 4'b0100;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_db  = (e >= 6) ? 4'b0100 : 4'b0011;
      exp_chg = (e == 6);
      checks++;
      if (sw_db !== exp_db || changed !== exp_chg)
        $display("FAIL clean e%0d: sw_db=%b changed=%b want %b %b", e, sw_db, changed, exp_db, exp_chg);
      else passes++;
    end
  endtask

  task automatic test_glitch();
    pins = 4'b0000;
    repeat (8) tick();
    pins = 4'b0001;
    for (int e = 1; e <= 12; e++) begin
      if (e == 3) pins = 4'b0000;
      tick();
      checks++;
      if (sw_db !== 4'b0000 || changed !== 1'b0)
        $display("FAIL glitch e%0d: sw_db=%b changed=%b want 0000 0", e, sw_db, changed);
      else passes++;
    end
  endtask

  task automatic test_bounce_restart();
    int c0, at;
    c0 = commits;
    at = -1;
    pins = 4'b1000; tick();
    pins = 4'b0000; tick();
    pins = 4'b1000;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (changed === 1'b1 && at < 0) at = e;
    end
    checks++;
    if (at != 6 || sw_db !== 4'b1000)
      $display("FAIL bounce: commit_edge=%0d sw_db=%b want 6 1000", at, sw_db);
    else passes++;
    checks++;
    if (commits - c0 != 1)
      $display("FAIL bounce_model_commits: got %0d want 1", commits - c0);
    else passes++;
  endtask

  task automatic test_reset_mid_settle();
    logic [3:0] exp_db;
    logic       exp_chg;
    pins = 4'b0000;
    repeat (8) tick();
    pins = 4'b1111;
    repeat (4) tick();
    checks++;
    if (sw_db !== 4'b0000 || changed !== 1'b0)
      $display("FAIL mid_settle_pre: sw_db=%b changed=%b want 0000 0", sw_db, changed);
    else passes++;
    rst_n = 1'b0;
    tick();
    checks++;
    if (sw_db !== 4'b0000 || changed !== 1'b0)
      $display("FAIL mid_settle_rst: sw_db=%b changed=%b want 0000 0", sw_db, changed);
    else passes++;
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_db  = (e >= 6) ? 4'b1111 : 4'b0000;
      exp_chg = (e == 6);
      checks++;
      if (sw_db !== exp_db || changed !== exp_chg)
        $display("FAIL mid_settle_recount e%0d: sw_db=%b changed=%b want %b %b", e, sw_db, changed, exp_db, exp_chg);
      else passes++;
    end
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 150; seg++) begin
      pins = 4'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 39) != 0);
      hold = $urandom_range(1, 8);
      for (int h = 0; h < hold; h++) begin
        tick();
        rst_n = 1'b1;
        checks++;
        if (sw_db !== m_db || changed !== m_chg)
          $display("FAIL random seg%0d: sw_db=%b changed=%b want %b %b", seg, sw_db, changed, m_db, m_chg);
        else passes++;
`ifdef SWITCH_DEBOUNCER_CHG_CNT_EN
        checks++;
        if (chg_cnt !== m_cnt)
          $display("FAIL random_chg_cnt seg%0d: chg_cnt=%0d want %0d", seg, chg_cnt, m_cnt);
        else passes++;
`endif
      end
    end
  endtask

`ifdef SWITCH_DEBOUNCER_CHG_CNT_EN
  task automatic test_chg_cnt_wrap();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 257; i++) begin
      pins = 4'((i % 15) + 1);
      repeat (7) tick();
    end
    checks++;
    if (chg_cnt !== 8'd1 || sw_db !== 4'd2)
      $display("FAIL chg_cnt_wrap: chg_cnt=%0d sw_db=%b want 1 0010", chg_cnt, sw_db);
    else passes++;
    checks++;
    if (chg_cnt !== m_cnt)
      $display("FAIL chg_cnt_model: chg_cnt=%0d want %0d", chg_cnt, m_cnt);
    else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_clean_change();
    test_glitch();
    test_bounce_restart();
    test_reset_mid_settle();
    test_random();
`ifdef SWITCH_DEBOUNCER_CHG_CNT_EN
    test_chg_cnt_wrap();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
